rob_commit: RTL and testbench

- Reorder buffer and in-order commit stage, sitting directly upstream of the retirement RAT.
- Accepts one renamed instruction per cycle from rename/dispatch and marks entries complete from writeback.
- Retires one completed instruction per cycle in program order. Commit outputs drive the retirement RAT write port and the free list (old physical tag).
- On a mispredicted branch at the head, raises a one-cycle flush after the branch commits.

---
 rtl/rob_commit.sv | 152 +++++++++++++++
 tb/tb_rob_commit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with single-wide in-order retire.
// A mispredicted branch retires, then a one-cycle flush pulse follows.
module rob_commit #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX   = 4,
  parameter int PHY_WIDTH = 6,
  parameter int PC_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic                 dispatch_has_rd,
  input  logic [4:0]           dispatch_rd_arch,
  input  logic [PHY_WIDTH-1:0] dispatch_rd_phy_new,
  input  logic [PHY_WIDTH-1:0] dispatch_rd_phy_old,
  output logic [ROB_IDX-1:0]   dispatch_rob_id,
  input  logic                 wb_valid,
  input  logic [ROB_IDX-1:0]   wb_rob_id,
  input  logic                 wb_mispredict,
  input  logic [PC_WIDTH-1:0]  wb_redirect_pc,
  output logic                 retire_valid,
  output logic [4:0]           rd_arch_commit,
  output logic [PHY_WIDTH-1:0] rd_phy_new_commit,
  output logic [PHY_WIDTH-1:0] rd_phy_old_commit,
  output logic                 retire_has_rd,
  output logic                 flush,
  output logic [PC_WIDTH-1:0]  flush_pc,
  output logic                 rob_empty,
  output logic                 rob_full
);

  // DRAIN is the cycle the mispredicted branch shows on retire_valid
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t state, state_nxt;

  logic [ROB_IDX:0]   head, tail;
  logic [ROB_IDX-1:0] hidx, tidx;

  logic [ROB_DEPTH-1:0] valid, done, mispred, has_rd;
  logic [4:0]           arch   [ROB_DEPTH];
  logic [PHY_WIDTH-1:0] phy_n  [ROB_DEPTH];
  logic [PHY_WIDTH-1:0] phy_o  [ROB_DEPTH];
  logic [PC_WIDTH-1:0]  rpc    [ROB_DEPTH];

  logic running, do_disp, do_wb, do_ret, do_flush;

  assign hidx = head[ROB_IDX-1:0];
  assign tidx = tail[ROB_IDX-1:0];

  assign rob_empty = (head == tail);
  assign rob_full  = (hidx == tidx) &&
                     (head[ROB_IDX] != tail[ROB_IDX]);
  assign dispatch_rob_id = tidx;

  assign running  = (state == RUN);
  assign do_disp  = dispatch_valid && dispatch_ready;
  assign do_wb    = running && wb_valid && valid[wb_rob_id];
  assign do_ret   = running && valid[hidx] && done[hidx];
  assign do_flush = do_ret && mispred[hidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    unique case (state)
      RUN:     state_nxt = do_flush ? DRAIN : RUN;
      DRAIN:   state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    flush          = (state == FLUSH);
    dispatch_ready = rst_n && running && !rob_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (do_flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_ret)  head <= head + 1'b1;
      if (do_disp) tail <= tail + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      done    <= '0;
      mispred <= '0;
      has_rd  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        arch[i]  <= '0;
        phy_n[i] <= '0;
        phy_o[i] <= '0;
        rpc[i]   <= '0;
      end
    end else begin
      if (do_wb) begin
        done[wb_rob_id]    <= 1'b1;
        mispred[wb_rob_id] <= wb_mispredict;
        rpc[wb_rob_id]     <= wb_redirect_pc;
      end
      if (do_disp) begin
        valid[tidx]   <= 1'b1;
        done[tidx]    <= 1'b0;
        mispred[tidx] <= 1'b0;
        has_rd[tidx]  <= dispatch_has_rd;
        arch[tidx]    <= dispatch_rd_arch;
        phy_n[tidx]   <= dispatch_rd_phy_new;
        phy_o[tidx]   <= dispatch_rd_phy_old;
      end
      if (do_ret) valid[hidx] <= 1'b0;
      // younger work behind a mispredict is discarded
      if (do_flush) begin
        valid <= '0;
        done  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_valid      <= 1'b0;
      retire_has_rd     <= 1'b0;
      rd_arch_commit    <= '0;
      rd_phy_new_commit <= '0;
      rd_phy_old_commit <= '0;
      flush_pc          <= '0;
    end else begin
      retire_valid <= do_ret;
      if (do_ret) begin
        retire_has_rd     <= has_rd[hidx];
        rd_arch_commit    <= arch[hidx];
        rd_phy_new_commit <= phy_n[hidx];
        rd_phy_old_commit <= phy_o[hidx];
      end
      if (do_flush) flush_pc <= rpc[hidx];
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: random + directed stimulus against a queue-based
// program-order model of the reorder buffer.
module tb_rob_commit;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dispatch_valid = 1'b0;
  logic        dispatch_ready;
  logic        dispatch_has_rd = 1'b0;
  logic [4:0]  dispatch_rd_arch = '0;
  logic [5:0]  dispatch_rd_phy_new = '0;
  logic [5:0]  dispatch_rd_phy_old = '0;
  logic [3:0]  dispatch_rob_id;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_rob_id = '0;
  logic        wb_mispredict = 1'b0;
  logic [31:0] wb_redirect_pc = '0;
  logic        retire_valid;
  logic [4:0]  rd_arch_commit;
  logic [5:0]  rd_phy_new_commit;
  logic [5:0]  rd_phy_old_commit;
  logic        retire_has_rd;
  logic        flush;
  logic [31:0] flush_pc;
  logic        rob_empty;
  logic        rob_full;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dispatch_valid      (dispatch_valid),
    .dispatch_ready      (dispatch_ready),
    .dispatch_has_rd     (dispatch_has_rd),
    .dispatch_rd_arch    (dispatch_rd_arch),
    .dispatch_rd_phy_new (dispatch_rd_phy_new),
    .dispatch_rd_phy_old (dispatch_rd_phy_old),
    .dispatch_rob_id     (dispatch_rob_id),
    .wb_valid            (wb_valid),
    .wb_rob_id           (wb_rob_id),
    .wb_mispredict       (wb_mispredict),
    .wb_redirect_pc      (wb_redirect_pc),
    .retire_valid        (retire_valid),
    .rd_arch_commit      (rd_arch_commit),
    .rd_phy_new_commit   (rd_phy_new_commit),
    .rd_phy_old_commit   (rd_phy_old_commit),
    .retire_has_rd       (retire_has_rd),
    .flush               (flush),
    .flush_pc            (flush_pc),
    .rob_empty           (rob_empty),
    .rob_full            (rob_full)
  );

  typedef struct {
    int          id;
    bit          done;
    bit          mp;
    logic [31:0] pc;
    bit          hrd;
    logic [4:0]  a;
    logic [5:0]  pn;
    logic [5:0]  po;
  } ent_t;

  typedef struct {
    logic [4:0] a;
    logic [5:0] pn;
    logic [5:0] po;
    logic       h;
    int         cyc;
  } rl_t;

  ent_t q[$];
  int   tcnt = 0;
  int   fl_cnt = 0;
  bit   e_rv = 0, e_hrd = 0, e_fl = 0;
  logic [4:0]  e_a = '0;
  logic [5:0]  e_pn = '0, e_po = '0;
  logic [31:0] e_fpc = '0;
  bit   m_rdy, m_ret, m_mp;
  int   n_vec = 0, n_err = 0, cyc = 0;

  rl_t  rlog[$];
  int   flog_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // program-order model: queue front is the oldest instruction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      tcnt = 0; fl_cnt = 0;
      e_rv = 0; e_hrd = 0; e_fl = 0;
      e_a = '0; e_pn = '0; e_po = '0; e_fpc = '0;
    end else begin
      cyc++;
      m_rdy = (fl_cnt == 0) && (q.size() < D);
      m_ret = (fl_cnt == 0) && (q.size() > 0) && q[0].done;
      m_mp  = m_ret && q[0].mp;
      e_rv  = m_ret;
      if (m_ret) begin
        e_a = q[0].a; e_pn = q[0].pn; e_po = q[0].po; e_hrd = q[0].hrd;
      end
      if (m_mp) e_fpc = q[0].pc;
      if (fl_cnt == 0 && wb_valid)
        foreach (q[i])
          if (q[i].id == int'(wb_rob_id)) begin
            q[i].done = 1; q[i].mp = wb_mispredict; q[i].pc = wb_redirect_pc;
          end
      if (m_ret) void'(q.pop_front());
      if (m_mp) begin
        q.delete();
        tcnt = 0;
        fl_cnt = 2;
      end else begin
        if (fl_cnt > 0) fl_cnt--;
        if (dispatch_valid && m_rdy) begin
          q.push_back('{tcnt % D, 1'b0, 1'b0, 32'h0, dispatch_has_rd,
                        dispatch_rd_arch, dispatch_rd_phy_new,
                        dispatch_rd_phy_old});
          tcnt = (tcnt + 1) % (2 * D);
        end
      end
      e_fl = (fl_cnt == 1);
    end
  end

  always @(negedge clk) begin
    chk("dispatch_ready", dispatch_ready,
        rst_n && fl_cnt == 0 && q.size() < D);
    chk("dispatch_rob_id", dispatch_rob_id, tcnt % D);
    chk("rob_empty", rob_empty, q.size() == 0);
    chk("rob_full", rob_full, q.size() == D);
    chk("retire_valid", retire_valid, e_rv);
    chk("flush", flush, e_fl);
    if (e_rv) begin
      chk("rd_arch_commit", rd_arch_commit, e_a);
      chk("rd_phy_new_commit", rd_phy_new_commit, e_pn);
      chk("rd_phy_old_commit", rd_phy_old_commit, e_po);
      chk("retire_has_rd", retire_has_rd, e_hrd);
    end
    if (e_fl) chk("flush_pc", flush_pc, e_fpc);
    if (retire_valid)
      rlog.push_back('{rd_arch_commit, rd_phy_new_commit,
                       rd_phy_old_commit, retire_has_rd, cyc});
    if (flush) flog_cyc.push_back(cyc);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic disp(input logic [4:0] a, input logic [5:0] pn,
                      input logic [5:0] po, input logic h);
    dispatch_valid = 1'b1;
    dispatch_rd_arch = a;
    dispatch_rd_phy_new = pn;
    dispatch_rd_phy_old = po;
    dispatch_has_rd = h;
    tick();
    dispatch_valid = 1'b0;
  endtask

  task automatic wb(input int id, input logic mp, input logic [31:0] pc);
    wb_valid = 1'b1;
    wb_rob_id = 4'(id);
    wb_mispredict = mp;
    wb_redirect_pc = pc;
    tick();
    wb_valid = 1'b0;
    wb_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    dispatch_valid = 1'b0;
    wb_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_empty", rob_empty, 1);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ready", dispatch_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_rob_id", dispatch_rob_id, 0);
    chk("rst_ready_after", dispatch_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("init_rob_id", dispatch_rob_id, 0);
    chk("init_empty", rob_empty, 1);

    // in-order retire despite out-of-order completion
    rlog.delete();
    disp(5'd3, 6'd33, 6'd3, 1'b1);
    disp(5'd4, 6'd34, 6'd4, 1'b1);
    disp(5'd5, 6'd35, 6'd5, 1'b1);
    wb(2, 1'b0, 32'h0);
    tick(3);
    chk("early_retire", rlog.size(), 0);
    wb(0, 1'b0, 32'h0);
    wb(1, 1'b0, 32'h0);
    tick(4);
    chk("inorder_count", rlog.size(), 3);
    if (rlog.size() == 3)
      for (int k = 0; k < 3; k++) begin
        chk("inorder_arch", rlog[k].a, 3 + k);
        chk("inorder_new", rlog[k].pn, 33 + k);
        chk("inorder_old", rlog[k].po, 3 + k);
        if (k > 0) chk("inorder_gap", rlog[k].cyc - rlog[k-1].cyc, 1);
      end

    // fill, stall, then wrap
    do_reset();
    for (int i = 0; i < D; i++) disp(5'(i), 6'(16 + i), 6'(i), 1'b1);
    chk("full_flag", rob_full, 1);
    chk("full_ready", dispatch_ready, 0);
    dispatch_valid = 1'b1;
    dispatch_rd_arch = 5'd31;
    wb(0, 1'b0, 32'h0);
    dispatch_valid = 1'b0;
    tick();
    chk("wrap_ready", dispatch_ready, 1);
    chk("wrap_rob_id", dispatch_rob_id, 0);
    disp(5'd20, 6'd20, 6'd20, 1'b1);
    chk("wrap_full_again", rob_full, 1);

    // mispredict at id1
    do_reset();
    for (int i = 0; i < 4; i++) disp(5'(i), 6'(40 + i), 6'(i), 1'b1);
    rlog.delete();
    flog_cyc.delete();
    wb(1, 1'b1, 32'h0000_0400);
    wb(0, 1'b0, 32'h0);
    tick();
    wb(2, 1'b0, 32'h0);
    chk("mp_branch_retire", retire_valid, 1);
    chk("mp_no_flush_yet", flush, 0);
    wb(3, 1'b0, 32'h0);
    chk("mp_flush", flush, 1);
    chk("mp_flush_pc", flush_pc, 32'h400);
    chk("mp_rv_in_flush", retire_valid, 0);
    tick();
    chk("mp_empty", rob_empty, 1);
    chk("mp_rob_id", dispatch_rob_id, 0);
    tick(3);
    chk("mp_retire_count", rlog.size(), 2);
    chk("mp_flush_count", flog_cyc.size(), 1);
    if (rlog.size() == 2 && flog_cyc.size() == 1) begin
      chk("mp_arch0", rlog[0].a, 0);
      chk("mp_arch1", rlog[1].a, 1);
      chk("mp_flush_after", flog_cyc[0] - rlog[1].cyc, 1);
    end

    // writeback to an invalid entry is dropped
    do_reset();
    rlog.delete();
    for (int i = 0; i < 3; i++) disp(5'(10 + i), 6'(i), 6'(i), 1'b1);
    wb(7, 1'b0, 32'h0);
    for (int i = 3; i < 8; i++) disp(5'(10 + i), 6'(i), 6'(i), 1'b1);
    for (int i = 0; i < 7; i++) wb(i, 1'b0, 32'h0);
    tick(4);
    chk("inv_count", rlog.size(), 7);
    chk("inv_not_empty", rob_empty, 0);
    wb(7, 1'b0, 32'h0);
    tick(3);
    chk("inv_count2", rlog.size(), 8);
    if (rlog.size() == 8) chk("inv_arch7", rlog[7].a, 17);

    // store without destination
    disp(5'd9, 6'd50, 6'd9, 1'b0);
    wb(8, 1'b0, 32'h0);
    tick(3);
    chk("store_count", rlog.size(), 9);
    if (rlog.size() == 9) chk("store_has_rd", rlog[8].h, 0);

    // random traffic
    do_reset();
    repeat (3000) begin
      dispatch_valid = ($urandom_range(0, 9) < 6);
      dispatch_has_rd = 1'($urandom);
      dispatch_rd_arch = 5'($urandom);
      dispatch_rd_phy_new = 6'($urandom);
      dispatch_rd_phy_old = 6'($urandom);
      wb_valid = 1'($urandom);
      wb_rob_id = 4'($urandom);
      wb_mispredict = ($urandom_range(0, 19) == 0);
      wb_redirect_pc = $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end
    dispatch_valid = 1'b0;
    wb_valid = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
